// File: rtl/scan_index_counter.sv
// Two-level (row, col) traversal counter for the Smith-Waterman array.
// Inner column counter nested in an outer row counter with latched inclusive tops.
module scan_index_counter #(
   parameter int ROW_BITS = 8,
   parameter int COL_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                en,
   input  logic                abort,
   input  logic                mode,
   input  logic [ROW_BITS-1:0] row_top,
   input  logic [COL_BITS-1:0] col_top,
   output logic [ROW_BITS-1:0] row,
   output logic [COL_BITS-1:0] col,
   output logic                busy,
   output logic                col_wrap,
   output logic                last,
   output logic                done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [ROW_BITS-1:0] ROW_ONE = {{(ROW_BITS-1){1'b0}}, 1'b1};
   localparam logic [COL_BITS-1:0] COL_ONE = {{(COL_BITS-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ROW_BITS-1:0] row_q, row_d, row_top_q, row_top_d;
   logic [COL_BITS-1:0] col_q, col_d, col_top_q, col_top_d;
   logic                mode_q, mode_d;
   logic                done_q, done_d;

   assign busy     = (state_q == RUN);
   assign col_wrap = busy && (col_q == col_top_q);
   assign last     = col_wrap && (row_q == row_top_q);
   assign row      = row_q;
   assign col      = col_q;
   assign done     = done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         row_top_q <= '0;
         col_top_q <= '0;
         mode_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         row_top_q <= row_top_d;
         col_top_q <= col_top_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
      end
   end

   // Wrapping is decided by compare against the latched tops, so an
   // all-ones top never relies on carry-out.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      row_top_d = row_top_q;
      col_top_d = col_top_q;
      mode_d    = mode_q;
      done_d    = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  row_top_d = row_top;
                  col_top_d = col_top;
                  mode_d    = mode;
                  row_d     = '0;
                  col_d     = '0;
                  state_d   = RUN;
               end
            end
            RUN: begin
               if (en) begin
                  if (last) begin
                     done_d = 1'b1;
                     if (mode_q) begin
                        row_d = '0;
                        col_d = '0;
                     end else begin
                        state_d = IDLE;
                     end
                  end else if (col_wrap) begin
                     col_d = '0;
                     row_d = row_q + ROW_ONE;
                  end else begin
                     col_d = col_q + COL_ONE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_index_counter.sv
// Self-checking bench for scan_index_counter: scoreboard queue of expected
// per-cycle outputs, a vector table for continuous/abort, and scan loops.
module tb_scan_index_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, en, abort, mode;
   logic [7:0] row_top, col_top;
   logic [7:0] row, col;
   logic       busy, col_wrap, last, done;
   logic [1:0] row2, col2;
   logic       busy2, wrap2, last2, done2;

   always #5 clk = ~clk;

   scan_index_counter #(.ROW_BITS(8), .COL_BITS(8)) dut (
      .clk(clk), .rst(rst), .start(start), .en(en), .abort(abort), .mode(mode),
      .row_top(row_top), .col_top(col_top), .row(row), .col(col), .busy(busy),
      .col_wrap(col_wrap), .last(last), .done(done));

   scan_index_counter #(.ROW_BITS(2), .COL_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .en(en), .abort(abort), .mode(mode),
      .row_top(row_top[1:0]), .col_top(col_top[1:0]), .row(row2), .col(col2),
      .busy(busy2), .col_wrap(wrap2), .last(last2), .done(done2));

   typedef struct packed {
      logic       sel;   // 0: 8-bit instance, 1: 2-bit instance
      logic       chk;   // compare row/col too
      logic [7:0] row;
      logic [7:0] col;
      logic       busy;
      logic       wrap;
      logic       last;
      logic       done;
   } exp_t;

   typedef struct packed {
      logic s;
      logic e;
      logic a;
      exp_t ex;
   } vec_t;

   exp_t  q[$];
   vec_t  tbl[21];
   int    n_cmp = 0;
   int    n_err = 0;
   string tname;

   function automatic exp_t mk(input logic sel, input logic chk, input logic [7:0] r,
                               input logic [7:0] c, input logic b, input logic w,
                               input logic l, input logic d);
      exp_t ex;
      ex.sel = sel; ex.chk = chk; ex.row = r; ex.col = c;
      ex.busy = b; ex.wrap = w; ex.last = l; ex.done = d;
      return ex;
   endfunction

   task automatic check();
      exp_t       ex;
      logic [7:0] ar, ac;
      logic       ab, aw, al, ad;
      if (q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: scoreboard empty", tname);
         return;
      end
      ex = q.pop_front();
      if (ex.sel) begin
         ar = {6'b0, row2}; ac = {6'b0, col2}; ab = busy2; aw = wrap2; al = last2; ad = done2;
      end else begin
         ar = row; ac = col; ab = busy; aw = col_wrap; al = last; ad = done;
      end
      n_cmp++;
      if (ab !== ex.busy || aw !== ex.wrap || al !== ex.last || ad !== ex.done ||
          (ex.chk && (ar !== ex.row || ac !== ex.col))) begin
         n_err++;
         $display("FAIL %s: got row=%0d col=%0d busy=%b wrap=%b last=%b done=%b, want row=%0d col=%0d busy=%b wrap=%b last=%b done=%b",
                  tname, ar, ac, ab, aw, al, ad, ex.row, ex.col, ex.busy, ex.wrap, ex.last, ex.done);
      end
   endtask

   // drive one cycle of inputs, queue the expectation for after the edge
   task automatic cyc(input logic s, input logic e, input logic a, input exp_t ex);
      start = s; en = e; abort = a;
      q.push_back(ex);
      @(posedge clk); #1;
      check();
   endtask

   function automatic exp_t elem(input logic sel, input int k, input int rt, input int ct);
      int r, c;
      r = k / (ct + 1);
      c = k % (ct + 1);
      return mk(sel, 1'b1, 8'(r), 8'(c), 1'b1, c == ct, (c == ct) && (r == rt), 1'b0);
   endfunction

   // one-shot scan with en=1; mid-scan top change and start must be ignored
   task automatic run_scan(input logic sel, input int rt, input int ct, input string nm);
      int n;
      tname = nm;
      n = (rt + 1) * (ct + 1);
      row_top = 8'(rt); col_top = 8'(ct); mode = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, elem(sel, 0, rt, ct));
      for (int k = 1; k < n; k++) begin
         if (k == n / 2) begin
            row_top = ~8'(rt); col_top = ~8'(ct); mode = 1'b1;
            cyc(1'b1, 1'b1, 1'b0, elem(sel, k, rt, ct));
         end else begin
            cyc(1'b0, 1'b1, 1'b0, elem(sel, k, rt, ct));
         end
      end
      cyc(1'b0, 1'b1, 1'b0, mk(sel, 1'b1, 8'(rt), 8'(ct), 1'b0, 1'b0, 1'b0, 1'b1));
      cyc(1'b0, 1'b1, 1'b0, mk(sel, 1'b1, 8'(rt), 8'(ct), 1'b0, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      // continuous 2x2 with ignored start, abort mid-scan, abort over last, abort over start
      tbl[0]  = '{1'b1, 1'b1, 1'b0, mk(0, 1, 0, 0, 1, 0, 0, 0)};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 1, 1, 1, 0, 0)};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 0, 1, 0, 0, 0)};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 1, 1, 1, 1, 0)};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 1, 0, 0, 1)};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, mk(0, 1, 0, 1, 1, 1, 0, 0)};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 0, 1, 0, 0, 0)};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 1, 1, 1, 1, 0)};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 1, 0, 0, 1)};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 1, 1, 1, 0, 0)};
      tbl[10] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[11] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[12] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[13] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[14] = '{1'b1, 1'b1, 1'b0, mk(0, 1, 0, 0, 1, 0, 0, 0)};
      tbl[15] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 1, 1, 1, 0, 0)};
      tbl[16] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 0, 1, 0, 0, 0)};
      tbl[17] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 1, 1, 1, 1, 0)};
      tbl[18] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[19] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[20] = '{1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0)};

      rst = 1'b0; start = 1'b0; en = 1'b0; abort = 1'b0; mode = 1'b0;
      row_top = 8'd0; col_top = 8'd0;
      #12;
      tname = "reset_state";
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
      check();
      rst = 1'b1;
      @(posedge clk); #1;

      run_scan(1'b0, 2, 3, "oneshot_3x4");

      // en alternates 0,1 per element: every index held two cycles
      tname = "stall_3x4";
      row_top = 8'd2; col_top = 8'd3; mode = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, elem(0, 0, 2, 3));
      for (int k = 0; k < 12; k++) begin
         cyc(1'b0, 1'b0, 1'b0, elem(0, k, 2, 3));
         if (k < 11) cyc(1'b0, 1'b1, 1'b0, elem(0, k + 1, 2, 3));
         else        cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 2, 3, 0, 0, 0, 1));
      end
      cyc(1'b0, 1'b0, 1'b0, mk(0, 1, 2, 3, 0, 0, 0, 0));

      tname = "cont_abort_table";
      row_top = 8'd1; col_top = 8'd1; mode = 1'b1;
      for (int i = 0; i < 21; i++) begin
         tname = $sformatf("cont_abort_vec%0d", i);
         cyc(tbl[i].s, tbl[i].e, tbl[i].a, tbl[i].ex);
      end

      run_scan(1'b0, 0, 0, "one_element");
      tname = "one_element_stall";
      cyc(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 1, 1, 1, 0));
      cyc(1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0, 1, 1, 1, 0));
      cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 1));
      run_scan(1'b0, 2, 0, "col_top0_wrap_every");
      run_scan(1'b0, 0, 255, "col_top_all_ones");

      // 2-bit instance, tops all-ones: 16 elements, no index past 3
      start = 1'b0; en = 1'b0; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      run_scan(1'b1, 3, 3, "w2_tops_3x3");

      // async reset mid-scan at (2,3), no clock edge needed
      tname = "reset_mid_scan";
      row_top = 8'd4; col_top = 8'd5; mode = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, elem(0, 0, 4, 5));
      for (int k = 1; k <= 15; k++) cyc(1'b0, 1'b1, 1'b0, elem(0, k, 4, 5));
      #2 rst = 1'b0;
      #1;
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
      check();
      #1 rst = 1'b1;
      @(posedge clk); #1;
      tname = "after_reset";
      cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0));
      cyc(1'b1, 1'b1, 1'b0, elem(0, 0, 4, 5));
      cyc(1'b0, 1'b1, 1'b0, elem(0, 1, 4, 5));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
